// File: rtl/led_pattern_driver.sv
// Three-LED pattern generator: a free-running prescaler paces the pattern steps,
// and a mode request is held pending until the next tick.
module led_pattern_driver #(
    parameter int TICK_DIV = 524288
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] MODE_IN,
    input  logic       MODE_STB,
    output logic       MODE_ACK,
    output logic       TICK_OUT,
    output logic       LED0,
    output logic       LED1,
    output logic       LED2
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {M_OFF, M_CHASE, M_BLINK, M_BINARY} mode_t;

    logic [CW-1:0] count;
    logic          tick;
    logic          load;
    mode_t         mode_reg;
    mode_t         pend_mode;
    mode_t         load_mode;
    logic          pend_flag;
    logic [2:0]    step;
    logic [2:0]    step_next;
    logic [2:0]    pattern;

    assign tick      = (count == LAST);
    assign TICK_OUT  = tick;
    // A strobe landing on the tick cycle itself wins over anything pending.
    assign load      = tick && (pend_flag || MODE_STB);
    assign load_mode = MODE_STB ? mode_t'(MODE_IN) : pend_mode;

    always_comb begin
        step_next = step;
        case (mode_reg)
            M_OFF:    step_next = 3'd0;
            M_CHASE:  step_next = (step == 3'd2) ? 3'd0 : step + 3'd1;
            M_BLINK:  step_next = (step == 3'd0) ? 3'd1 : 3'd0;
            M_BINARY: step_next = step + 3'd1;
            default:  step_next = 3'd0;
        endcase
    end

    always_comb begin
        pattern = 3'b000;
        case (mode_reg)
            M_OFF:    pattern = 3'b000;
            M_CHASE: begin
                case (step)
                    3'd0:    pattern = 3'b001;
                    3'd1:    pattern = 3'b010;
                    default: pattern = 3'b100;
                endcase
            end
            M_BLINK:  pattern = (step == 3'd0) ? 3'b111 : 3'b000;
            M_BINARY: pattern = step;
            default:  pattern = 3'b000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count     <= '0;
            mode_reg  <= M_OFF;
            pend_mode <= M_OFF;
            pend_flag <= 1'b0;
            step      <= 3'd0;
            MODE_ACK  <= 1'b0;
            {LED2, LED1, LED0} <= 3'b000;
        end else begin
            count    <= tick ? '0 : count + 1'b1;
            MODE_ACK <= load;
            {LED2, LED1, LED0} <= pattern;
            if (load) begin
                mode_reg  <= load_mode;
                step      <= 3'd0;
                pend_flag <= 1'b0;
            end else begin
                if (MODE_STB) begin
                    pend_mode <= mode_t'(MODE_IN);
                    pend_flag <= 1'b1;
                end
                if (tick)
                    step <= step_next;
            end
        end
    end
endmodule

// File: doc/led_pattern_driver.md
LED_PATTERN_DRIVER -- requirements
Module: led_pattern_driver

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 524288, giving the number of CLK cycles per pattern tick (legal range 2 to 2^24).
REQ-002 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 MODE_IN  input  2  requested pattern: 0 OFF, 1 CHASE, 2 BLINK, 3 BINARY.
REQ-005 MODE_STB  input  1  one-cycle strobe; MODE_IN is sampled when this is high.
REQ-006 MODE_ACK  output  1  one-cycle pulse when a requested mode becomes active.
REQ-007 TICK_OUT  output  1  one-cycle pulse per prescaler period.
REQ-008 LED0, LED1, LED2  output  1 each  registered LED drives, active-high.

Function
REQ-009 Prescaler counter SHALL count 0..TICK_DIV-1 and then wrap to 0; tick SHALL be high exactly in the cycle where the count equals TICK_DIV-1; TICK_OUT SHALL equal tick.
REQ-010 Strobe capture SHALL load MODE_IN into pend_mode and set pend_flag; a later strobe before the tick SHALL overwrite pend_mode (last one wins).
REQ-011 Mode load SHALL occur on the edge where tick=1 and either pend_flag=1 or MODE_STB=1:
- mode_reg gets MODE_IN if MODE_STB=1, else pend_mode.
- step is cleared to 0.
- pend_flag is cleared.
- MODE_ACK is high during the following cycle only.
REQ-012 On a tick with no mode load, step SHALL advance per mode_reg:
- OFF: held at 0.
- CHASE: 0->1->2->0.
- BLINK: 0->1->0.
- BINARY: 0..7, then 7->0.
REQ-013 Step width SHALL be 3 bits; no value outside the current mode's range SHALL ever be reached.
REQ-014 Pattern decode {LED2,LED1,LED0} SHALL be:
- OFF: 000.
- CHASE: step 0/1/2 gives 001/010/100.
- BLINK: step 0 gives 111, step 1 gives 000.
- BINARY: step[2:0].
REQ-015 LED outputs SHALL be registered from mode_reg/step, so they reflect a step or mode change exactly one cycle after the edge that changed it.
REQ-016 A strobe with the same value as mode_reg SHALL still be processed as a mode load (step restarts at 0, MODE_ACK pulses).
REQ-017 Prescaler SHALL free-run; mode loads SHALL NOT reset it.
REQ-018 Without ticks, pend_flag SHALL persist indefinitely; no strobe SHALL be lost except by overwrite under REQ-010.

Reset
REQ-019 On a rising edge with RST=1, all of the following SHALL be cleared: prescaler, step, mode_reg (OFF), pend_mode, pend_flag, MODE_ACK, TICK_OUT, LED0-2.
REQ-020 RST SHALL override MODE_STB and tick in the same cycle; that strobe is discarded.
REQ-021 Reset mid-pattern SHALL yield LEDs 000 in the cycle after the reset edge; the first tick SHALL then occur TICK_DIV cycles after RST deasserts.

Verification (TICK_DIV=4)
REQ-022 Reset then idle 20 cycles -> TICK_OUT pulses every 4 cycles; LEDs stay 000; MODE_ACK stays 0.
REQ-023 Strobe MODE_IN=1 between ticks -> MODE_ACK pulses one cycle after the next tick; LEDs show 001, 010, 100, 001 on successive ticks (each one cycle after its tick).
REQ-024 Strobe 3 then 2 before one tick -> only BLINK loads, with a single MODE_ACK; LEDs alternate 111/000 per tick.
REQ-025 MODE_STB=1 with MODE_IN=3 in the same cycle as tick -> BINARY loads at that edge; LEDs count 000..111 and wrap to 000 after 8 ticks.
REQ-026 RST asserted mid-CHASE together with MODE_STB -> LEDs 000 next cycle; mode stays OFF after the next tick; no MODE_ACK.
